// File: rtl/pmem_burst_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_burst_bridge_pkg
//  Purpose  : Shared types and default geometry for the cache-line to
//             memory-burst bridge. Holds the FSM state encoding and the
//             default line and beat widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pmem_burst_bridge_pkg;

  // Bridge control states. The explicit 2-bit width keeps the state
  // register size independent of the number of states listed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Default geometry: 32-byte lines moved as four 64-bit beats.
  localparam int c_S_OFFSET = 5;
  localparam int c_S_LINE   = 8 * (2 ** c_S_OFFSET);
  localparam int c_S_BEAT   = 64;

endpackage : pmem_burst_bridge_pkg
`default_nettype wire

// File: rtl/pmem_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : pmem_burst_bridge
//  Purpose  : Converts whole-line read/write requests from a cache into
//             ascending-order multi-beat bursts on a narrower memory port.
//  Ports    : clk, rst_n         - clock, synchronous active-low reset
//             pmem_read/write    - line request (held until pmem_resp)
//             pmem_address       - line address (low s_offset bits dropped)
//             pmem_wdata         - line write data
//             pmem_resp          - one-cycle completion pulse
//             pmem_rdata         - assembled read line
//             mem_read/write     - burst request, high for the whole burst
//             mem_address        - line-aligned burst base address
//             mem_wdata          - current write beat
//             mem_rdata          - current read beat
//             mem_resp           - per-beat strobe
//  Revision : 1.0 - initial release
// ============================================================================
module pmem_burst_bridge
  import pmem_burst_bridge_pkg::*;
#(
  parameter int s_offset = c_S_OFFSET,
  parameter int s_line   = c_S_LINE,
  parameter int s_beat   = c_S_BEAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [s_line-1:0] pmem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [s_beat-1:0] mem_wdata,
  input  logic [s_beat-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int                 c_BEATS     = s_line / s_beat;
  localparam int                 c_CNT_W     = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);
  // Masking (rather than slicing) keeps every address bit in use.
  localparam logic [31:0]        c_ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

  state_t              r_state;
  state_t              w_next_state;
  logic [c_CNT_W-1:0]  r_beat;
  logic [31:0]         r_addr;
  logic [s_line-1:0]   r_wline;
  logic [s_line-1:0]   r_rline;
  logic                w_last_beat;

  assign w_last_beat = mem_resp && (r_beat == c_LAST_BEAT);

  // ---------------------------------------------------------------------------
  // Next state and control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    pmem_resp    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    case (r_state)
      IDLE: begin
        // Write has priority when both requests are raised together.
        if (pmem_write) begin
          w_next_state = WRITE;
        end else if (pmem_read) begin
          w_next_state = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        if (w_last_beat) begin
          w_next_state = DONE;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        if (w_last_beat) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        pmem_resp    = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, beat counter, latched request and line buffers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rline <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (pmem_write) begin
            r_addr  <= pmem_address & c_ALIGN_MASK;
            r_wline <= pmem_wdata;
            r_beat  <= '0;
          end else if (pmem_read) begin
            r_addr  <= pmem_address & c_ALIGN_MASK;
            r_beat  <= '0;
          end
        end
        READ: begin
          if (mem_resp) begin
            r_rline[int'(r_beat) * s_beat +: s_beat] <= mem_rdata;
            // Hold at the last beat so the counter never wraps inside a burst.
            if (!w_last_beat) begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_resp && !w_last_beat) begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_address = r_addr;
  assign mem_wdata   = r_wline[int'(r_beat) * s_beat +: s_beat];
  // The read buffer is only touched by read beats, so writes leave it intact.
  assign pmem_rdata  = r_rline;

endmodule : pmem_burst_bridge
`default_nettype wire

// File: tb/tb_pmem_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmem_burst_bridge
//  Purpose  : Self-checking bench for pmem_burst_bridge. The bench plays the
//             memory side and compares against a line-level reference model.
//  Ports    : none (testbench top)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_burst_bridge;

  logic         clk;
  logic         rst_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state: the line the bridge should be presenting.
  logic [255:0] exp_rline;
  int           resp_cyc_a;
  int           resp_cyc_b;

  pmem_burst_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Full line read; bench returns beat k of 'line' after 'gap' idle cycles
  // (gap < 0 picks 0..2 at random per beat). 'hold' keeps pmem_read high.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input int gap, input bit hold);
    int waited;
    int acc;
    int gaps_total;
    int g;
    logic [31:0] aligned;
    aligned      = addr & 32'hFFFF_FFE0;
    gaps_total   = 0;
    pmem_read    = 1'b1;
    pmem_address = addr;
    waited       = 0;
    do begin
      tick();
      waited++;
    end while (mem_read !== 1'b1 && waited < 4);
    check("rd_accept_cycles", waited, 1);
    check("rd_mem_read", mem_read, 1'b1);
    check("rd_no_write", mem_write, 1'b0);
    check("rd_addr", mem_address, aligned);
    acc = cyc;
    pmem_address = $urandom;
    for (int k = 0; k < 4; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      gaps_total += g;
      repeat (g) begin
        mem_resp  = 1'b0;
        mem_rdata = {$urandom, $urandom};
        tick();
        check("rd_gap_no_resp", pmem_resp, 1'b0);
      end
      mem_resp  = 1'b1;
      mem_rdata = line[k*64 +: 64];
      tick();
      if (k < 3) check("rd_addr_stable", mem_address, aligned);
    end
    mem_resp  = 1'b0;
    mem_rdata = '0;
    check("rd_resp", pmem_resp, 1'b1);
    check("rd_latency", cyc - acc, 4 + gaps_total);
    check("rd_data", pmem_rdata, line);
    check("rd_done_no_read", mem_read, 1'b0);
    exp_rline = line;
    resp_cyc_a = resp_cyc_b;
    resp_cyc_b = cyc;
    if (!hold) pmem_read = 1'b0;
    tick();
    check("rd_resp_one_cycle", pmem_resp, 1'b0);
    check("rd_data_stable", pmem_rdata, exp_rline);
  endtask

  // Full line write; 'both' raises pmem_read alongside pmem_write.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input int gap, input bit both);
    int g;
    pmem_write   = 1'b1;
    pmem_read    = both;
    pmem_address = addr;
    pmem_wdata   = line;
    tick();
    check("wr_mem_write", mem_write, 1'b1);
    check("wr_no_read", mem_read, 1'b0);
    check("wr_addr", mem_address, addr & 32'hFFFF_FFE0);
    pmem_wdata   = rand_line();
    pmem_address = $urandom;
    for (int k = 0; k < 4; k++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin
        mem_resp = 1'b0;
        check("wr_beat_hold", mem_wdata, line[k*64 +: 64]);
        check("wr_gap_no_read", mem_read, 1'b0);
        tick();
      end
      check("wr_beat", mem_wdata, line[k*64 +: 64]);
      mem_resp = 1'b1;
      tick();
    end
    mem_resp = 1'b0;
    check("wr_resp", pmem_resp, 1'b1);
    check("wr_rdata_unchanged", pmem_rdata, exp_rline);
    check("wr_done_no_write", mem_write, 1'b0);
    pmem_write = 1'b0;
    pmem_read  = 1'b0;
    tick();
    check("wr_resp_one_cycle", pmem_resp, 1'b0);
    check("wr_idle_no_read", mem_read, 1'b0);
    check("wr_idle_no_write", mem_write, 1'b0);
  endtask

  initial begin
    logic [255:0] l;
    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem_rdata    = '0;
    mem_resp     = 1'b0;
    exp_rline    = '0;
    resp_cyc_a   = 0;
    resp_cyc_b   = 0;

    // Reset state
    repeat (3) tick();
    check("rst_pmem_resp", pmem_resp, 1'b0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_pmem_rdata", pmem_rdata, 256'h0);
    rst_n = 1'b1;
    tick();

    // Directed read, back-to-back beats
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read(32'h0000_1234, l, 0, 1'b0);

    // Directed write with two idle cycles before every beat
    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_write(32'h0000_8F3C, l, 2, 1'b0);

    // Read and write together: write burst only
    do_write($urandom, rand_line(), -1, 1'b1);

    // Reset after beat 1 of a read
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_4440;
    tick();
    for (int k = 0; k < 2; k++) begin
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
      tick();
    end
    mem_resp  = 1'b0;
    pmem_read = 1'b0;
    rst_n     = 1'b0;
    tick();
    rst_n     = 1'b1;
    exp_rline = '0;
    check("abort_mem_read", mem_read, 1'b0);
    check("abort_mem_write", mem_write, 1'b0);
    check("abort_pmem_resp", pmem_resp, 1'b0);
    check("abort_mem_address", mem_address, 32'h0);
    check("abort_mem_wdata", mem_wdata, 64'h0);
    check("abort_pmem_rdata", pmem_rdata, 256'h0);
    repeat (3) begin
      tick();
      check("abort_no_resp", pmem_resp, 1'b0);
    end
    do_read($urandom, rand_line(), -1, 1'b0);

    // Stray beat strobes while idle are ignored
    repeat (3) begin
      mem_resp  = 1'b1;
      mem_rdata = {$urandom, $urandom};
      tick();
      check("stray_no_resp", pmem_resp, 1'b0);
      check("stray_no_read", mem_read, 1'b0);
      check("stray_rdata", pmem_rdata, exp_rline);
    end
    mem_resp = 1'b0;
    do_read($urandom, rand_line(), -1, 1'b0);

    // Read held across two requests
    do_read($urandom, rand_line(), 0, 1'b1);
    do_read($urandom, rand_line(), 0, 1'b0);
    check("b2b_spacing_ge6", (resp_cyc_b - resp_cyc_a) >= 6, 1'b1);

    // Randomised mix
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) do_read($urandom, rand_line(), -1, 1'b0);
      else                           do_write($urandom, rand_line(), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pmem_burst_bridge
`default_nettype wire

// File: doc/pmem_burst_bridge.md
PMEM_BURST_BRIDGE -- requirements
Module: pmem_burst_bridge

Interface
REQ-001 SHALL have parameter s_offset, default 5, meaning log2 bytes per line.
REQ-002 SHALL have parameter s_line, default 256, meaning line width in bits (8*2**s_offset).
REQ-003 SHALL have parameter s_beat, default 64, meaning memory-side beat width in bits; beats per line = s_line/s_beat (4).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pmem_read  input  1  line read request from cache side, held until pmem_resp.
REQ-007 SHALL have port pmem_write  input  1  line write request from cache side, held until pmem_resp.
REQ-008 SHALL have port pmem_address  input  32  line request address.
REQ-009 SHALL have port pmem_wdata  input  s_line  line write data.
REQ-010 SHALL have port pmem_resp  output  1  one-cycle completion pulse.
REQ-011 SHALL have port pmem_rdata  output  s_line  assembled read line.
REQ-012 SHALL have port mem_read  output  1  burst read request.
REQ-013 SHALL have port mem_write  output  1  burst write request.
REQ-014 SHALL have port mem_address  output  32  burst base address, line-aligned.
REQ-015 SHALL have port mem_wdata  output  s_beat  current write beat.
REQ-016 SHALL have port mem_rdata  input  s_beat  current read beat.
REQ-017 SHALL have port mem_resp  input  1  per-beat strobe: read beat valid / write beat accepted.

Function
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-019 In IDLE with pmem_write=1 SHALL latch {pmem_address[31:s_offset], s_offset'b0} and pmem_wdata, clear beat counter, go to WRITE.
REQ-020 In IDLE with pmem_read=1 and pmem_write=0 SHALL latch the aligned address, clear beat counter, go to READ; write wins if both are asserted.
REQ-021 mem_read SHALL be 1 exactly in READ, mem_write exactly in WRITE; mem_address SHALL equal the latched aligned address and stay constant for the whole burst.
REQ-022 Beat order SHALL be ascending: beat k maps to line bits [k*s_beat +: s_beat], k = 0..3.
REQ-023 In WRITE, mem_wdata SHALL present latched beat k; each cycle with mem_resp=1 SHALL advance k.
REQ-024 In READ, each cycle with mem_resp=1 SHALL store mem_rdata into line buffer slot k and advance k; mem_resp may arrive on non-consecutive cycles.
REQ-025 On mem_resp for beat 3 SHALL go to DONE; the 2-bit counter SHALL never wrap mid-burst.
REQ-026 In DONE SHALL assert pmem_resp for exactly one cycle, then return to IDLE unconditionally.
REQ-027 Minimum latency SHALL be 6 cycles from request sampled in IDLE to pmem_resp (1 accept + 4 beats + DONE).
REQ-028 pmem_rdata SHALL be the line buffer, stable from DONE until the next read's first beat; writes SHALL NOT alter it.
REQ-029 mem_resp in IDLE or DONE SHALL be ignored; pmem_* changes after acceptance SHALL be ignored until IDLE.
REQ-030 The cycle after DONE SHALL be IDLE and SHALL accept a new request whenever one is asserted.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, beat counter 0, latched address 0, line buffer 0, from any state including mid-burst.
REQ-032 After that edge pmem_resp, mem_read, mem_write SHALL be 0, mem_address 0, mem_wdata 0, pmem_rdata 0; no pmem_resp for the aborted request.

Structure
REQ-033 A shared package SHALL hold the FSM state enum and the default line/beat width constants.
REQ-034 No sub-module is required; counter, FSM and buffers SHALL reside in pmem_burst_bridge.

Verification
REQ-035 Read, back-to-back beats 0x11..,0x22..,0x33..,0x44.. at address 0x0000_1234 -> mem_address 0x0000_1220, pmem_resp on cycle 6, pmem_rdata = {beat3,beat2,beat1,beat0}.
REQ-036 Write of line 0x..DDCCBBAA-pattern with mem_resp gaps of 2 idle cycles -> mem_wdata holds beat k until its mem_resp, one pmem_resp after beat 3, pmem_rdata unchanged.
REQ-037 pmem_read and pmem_write both 1 -> WRITE burst only, mem_read never asserted.
REQ-038 rst_n=0 after beat 1 of a read -> next cycle IDLE, all outputs 0, no pmem_resp; a fresh read then completes normally.
REQ-039 Stray mem_resp pulses in IDLE, then read -> only in-burst beats captured, pmem_resp once.
REQ-040 Read held continuously across two requests -> two pmem_resp pulses separated by at least 6 cycles, no lost or duplicate beats.
